// File: rtl/z80_bus_arbiter.sv
// rtl/z80_bus_arbiter.sv - CPU/host single-port memory arbiter using the Z80 BUSRQ/BUSAK handshake
// Optional feature macro: Z80ARB_HOLD_EN (held host_req bursts of up to MAX_BURST accesses per grant)
module z80_bus_arbiter #(
    parameter int MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    input  logic        cpu_mreq_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_busak_n,
    output logic        cpu_busrq_n,
    output logic [7:0]  cpu_di,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_busy,
    output logic [15:0] mem_a,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata
);

`ifdef Z80ARB_HOLD_EN
    localparam logic HOLD_EN = 1'b1;
`else
    localparam logic HOLD_EN = 1'b0;
`endif

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACCESS,
        S_DATA,
        S_CHECK,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  burst_q, burst_d;
    logic        host_ack_q, host_ack_d;
    logic [7:0]  host_rdata_q, host_rdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            burst_q      <= 8'h00;
            host_ack_q   <= 1'b0;
            host_rdata_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // The ack and read data are registered together at the end of DATA, so the
    // host sees them in the same cycle (the CHECK cycle) and can decide there.
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        host_ack_d   = 1'b0;
        host_rdata_d = host_rdata_q;
        cpu_busrq_n  = 1'b1;
        mem_a        = cpu_a;
        mem_wdata    = cpu_do;
        mem_we       = ~cpu_mreq_n & ~cpu_wr_n;

        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    state_d = S_REQ;
                    burst_d = 8'h00;
                end
            end
            S_REQ: begin
                cpu_busrq_n = 1'b0;
                if (!cpu_busak_n) state_d = S_ACCESS;
            end
            S_ACCESS: begin
                cpu_busrq_n = 1'b0;
                mem_a       = host_addr;
                mem_wdata   = host_wdata;
                mem_we      = host_we;
                if (burst_q != 8'hFF) burst_d = burst_q + 8'h01;
                state_d     = S_DATA;
            end
            S_DATA: begin
                cpu_busrq_n = 1'b0;
                mem_a       = host_addr;
                mem_wdata   = host_wdata;
                mem_we      = 1'b0;
                host_ack_d  = 1'b1;
                if (!host_we) host_rdata_d = mem_rdata;
                state_d     = S_CHECK;
            end
            S_CHECK: begin
                // CPU is still parked here, so the bus stays with the host
                cpu_busrq_n = 1'b0;
                mem_a       = host_addr;
                mem_wdata   = host_wdata;
                mem_we      = 1'b0;
                if (HOLD_EN && host_req && (burst_q < BURST_LIM)) state_d = S_ACCESS;
                else                                               state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (cpu_busak_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign cpu_di     = mem_rdata;
    assign host_ack   = host_ack_q;
    assign host_rdata = host_rdata_q;
    assign host_busy  = (state_q != S_IDLE);

endmodule
